// File: rtl/dmac_pkg.sv
// Shared types and default sizing for the DMAC channel arbiter.
// Holds the arbiter state encoding and default parameter constants.
package dmac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_BURST_MAX = 16;

endpackage

// File: rtl/dmac_channel_arbiter_if.sv
// Request/grant/enable bundle between the arbiter and its neighbours.
// master: the arbiter itself; slave: peripherals, AHB arbiter, engines.
interface dmac_channel_arbiter_if
    import dmac_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
);
    localparam int IDX_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] dma_req;
    logic              bus_grant;
    logic              xfer_beat;
    logic              xfer_done;
    logic              bus_req;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] req_ack;
    logic [IDX_W-1:0]  active_ch;
    logic              busy;

    modport master (
        input  dma_req, bus_grant, xfer_beat, xfer_done,
        output bus_req, ch_en, req_ack, active_ch, busy
    );

    modport slave (
        output dma_req, bus_grant, xfer_beat, xfer_done,
        input  bus_req, ch_en, req_ack, active_ch, busy
    );

endinterface

// File: rtl/dmac_rr_picker.sv
// Combinational winner selection among pending channel requests.
// DMAC_ARB_FIXED_PRIO_EN: highest index wins, pointer ignored.
module dmac_rr_picker #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              valid,
    output logic [IDX_W-1:0]  idx
);

`ifdef DMAC_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Last set bit scanning upward is the highest-index requester.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end
`else
    // Scan from farthest to nearest after ptr so the nearest wins.
    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            j = (int'(ptr) + k) % NUM_CH;
            if (req[IDX_W'(j)]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/dmac_channel_arbiter.sv
// Shares the DMAC AHB master port among NUM_CH request lines.
// Build option DMAC_ARB_FIXED_PRIO_EN selects fixed priority.
module dmac_channel_arbiter
    import dmac_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    dmac_channel_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_t        state;
    logic [IDX_W-1:0]  act;
    logic [IDX_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ack_q;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [NUM_CH-1:0] act_oh;
    logic              others;
    logic              sat;

    dmac_rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req   (bus.dma_req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign sat = (cnt == CNT_W'(BURST_MAX));

    // One-hot of the owner and whether a rival may pre-empt it.
    always_comb begin
        act_oh      = '0;
        act_oh[act] = 1'b1;
        others      = 1'b0;
`ifdef DMAC_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.dma_req[i] && (IDX_W'(i) > act)) begin
                others = 1'b1;
            end
        end
`else
        others = |(bus.dma_req & ~act_oh);
`endif
    end

    // Arbitration FSM: pick, request bus, own it, release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            act   <= '0;
            ptr   <= IDX_W'(NUM_CH - 1);
            cnt   <= '0;
            ack_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        act   <= pick_idx;
                        cnt   <= '0;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.bus_grant) begin
                        state <= XFER;
                        ack_q <= (cnt == '0);
                    end
                end
                XFER: begin
                    if (bus.xfer_done) begin
                        state <= RELEASE;
                    end else if (!bus.bus_grant) begin
                        state <= REQ;
                        if (bus.xfer_beat && !sat) begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (sat) begin
                        if (others) begin
                            state <= RELEASE;
                        end else begin
                            cnt <= '0;
                        end
                    end else if (bus.xfer_beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
`ifndef DMAC_ARB_FIXED_PRIO_EN
                    ptr <= act;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bus_req   = (state == REQ) || (state == XFER);
    assign bus.ch_en     = (state == XFER) ? act_oh : '0;
    assign bus.req_ack   = ack_q ? act_oh : '0;
    assign bus.active_ch = act;
    assign bus.busy      = (state != IDLE);

endmodule
